// File: rtl/round_ctrl_if.sv
// round_ctrl_if: player/timer signals between the round controller and its surroundings
interface round_ctrl_if;
    logic       start;
    logic       submit;
    logic [7:0] answer_v;
    logic       end_f;
    logic       time_f;
    logic [4:0] time_v;
    logic [7:0] target;
    logic [3:0] score;
    logic [3:0] round;
    logic       hit;
    logic       miss;
    logic       busy;
    logic       game_over;
    modport master (
        output start, submit, answer_v, end_f,
        input  time_f, time_v, target, score, round, hit, miss, busy, game_over
    );
    modport slave (
        input  start, submit, answer_v, end_f,
        output time_f, time_v, target, score, round, hit, miss, busy, game_over
    );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: binary-guessing game round sequencer; define ROUND_SPEEDUP_EN to shorten each round's time down to MIN_TIME
module round_ctrl #(
    parameter int ROUNDS     = 10,
    parameter int ROUND_TIME = 20,
    parameter int MIN_TIME   = 5
) (
    input logic        clk,
    input logic        rst_n,
    round_ctrl_if.slave io
);
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, JUDGE, DONE} state_t;
    state_t     state, state_nx;
    logic [7:0] lfsr;
    logic [7:0] target;
    logic [7:0] answer;
    logic       timeout;
    logic [4:0] time_q;
    logic [4:0] round_time;
    logic [3:0] score;
    logic [3:0] round;
    logic       correct;
    logic       last_round;
`ifdef ROUND_SPEEDUP_EN
    logic [5:0] diff;
    assign diff       = 6'(ROUND_TIME) - {2'b00, round};
    assign round_time = (diff[5] || diff < 6'(MIN_TIME)) ? 5'(MIN_TIME) : diff[4:0];
`else
    localparam int FIXED_TIME = (ROUND_TIME >= MIN_TIME) ? ROUND_TIME : MIN_TIME;
    assign round_time = 5'(FIXED_TIME);
`endif
    assign correct    = (answer == target) && !timeout;
    assign last_round = (round + 4'd1) == 4'(ROUNDS);
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state decode: start only acts when idle or done, submit/expiry only in play
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = io.start ? LOAD : state;
            LOAD:       state_nx = PLAY;
            PLAY:       state_nx = (io.submit || io.end_f) ? JUDGE : PLAY;
            JUDGE:      state_nx = last_round ? DONE : LOAD;
            default:    state_nx = IDLE;
        endcase
    end
    // datapath: free-running LFSR, target/time capture, answer latch, score and round counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr    <= 8'hA5;
            target  <= '0;
            answer  <= '0;
            timeout <= 1'b0;
            time_q  <= '0;
            score   <= '0;
            round   <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if ((state == IDLE || state == DONE) && io.start) begin
                score <= '0;
                round <= '0;
            end
            if (state == LOAD) begin
                target <= lfsr;
                time_q <= round_time;
            end
            if (state == PLAY && (io.submit || io.end_f)) begin
                answer  <= io.answer_v;
                timeout <= !io.submit;
            end
            if (state == JUDGE) begin
                round <= round + 4'd1;
                score <= correct ? score + 4'd1 : score;
            end
        end
    end
    // outputs: time_v shows the live round time while loading, otherwise the last loaded value
    always_comb begin
        io.time_f    = state == LOAD;
        io.time_v    = (state == LOAD) ? round_time : time_q;
        io.target    = target;
        io.score     = score;
        io.round     = round;
        io.hit       = state == JUDGE && correct;
        io.miss      = state == JUDGE && !correct;
        io.busy      = state == LOAD || state == PLAY || state == JUDGE;
        io.game_over = state == DONE;
    end
endmodule
